// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory fetch path.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_RD2  = 3'd4,
    S_RD3  = 3'd5,
    S_RDW  = 3'd6,
    S_DONE = 3'd7
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          IMEM_DEPTH = 2048;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Arbitrates core word fetches and loader byte writes onto a single-port,
// byte-wide, synchronous-read instruction memory; words are assembled MSB first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate loader vs fetch, check fetch address
// WR     | loader byte write, ld_ack
// RD0..3 | read bytes addr+0..3, capture the previous access's byte
// RDW    | no access, capture the last byte
// DONE   | fetch_valid pulse (word, or NOP with fetch_err)
module imem_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter int          DEPTH     = riscv_pkg::IMEM_DEPTH,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);

  fetch_state_t      r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:8]       r_word;
  logic              r_last_was_ld;
  logic              r_fetch_valid;
  logic              r_fetch_err;
  logic [31:0]       r_fetch_instr;

  logic [32:0]       w_end;
  logic              w_addr_bad;
  logic              w_ld_win;

  // 33-bit sum so an address near 2**32 cannot wrap back into range
  assign w_end      = {1'b0, fetch_addr} + 33'd3;
  assign w_addr_bad = (fetch_addr[1:0] != 2'b00) || (w_end > LAST_ADDR);
  assign w_ld_win   = ld_req && !(fetch_req && r_last_was_ld);

  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;
  assign fetch_instr = r_fetch_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    fetch_ready = 1'b0;
    ld_ack      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_ld_win) begin
          w_next = S_WR;
        end else if (fetch_req) begin
          fetch_ready = 1'b1;
          w_next      = w_addr_bad ? S_DONE : S_RD0;
        end
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        ld_ack    = 1'b1;
        w_next    = S_IDLE;
      end
      S_RD0: begin
        mem_en   = 1'b1;
        mem_addr = r_addr;
        w_next   = S_RD1;
      end
      S_RD1: begin
        mem_en   = 1'b1;
        mem_addr = r_addr + ADDR_W'(1);
        w_next   = S_RD2;
      end
      S_RD2: begin
        mem_en   = 1'b1;
        mem_addr = r_addr + ADDR_W'(2);
        w_next   = S_RD3;
      end
      S_RD3: begin
        mem_en   = 1'b1;
        mem_addr = r_addr + ADDR_W'(3);
        w_next   = S_RDW;
      end
      S_RDW:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr        <= '0;
      r_word        <= '0;
      r_last_was_ld <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_instr <= '0;
    end else begin
      r_fetch_valid <= (w_next == S_DONE);
      if (fetch_ready) begin
        r_addr        <= fetch_addr[ADDR_W-1:0];
        r_last_was_ld <= 1'b0;
        if (w_addr_bad) begin
          r_fetch_instr <= NOP_INSTR;
          r_fetch_err   <= 1'b1;
        end
      end
      if (r_state == S_WR) r_last_was_ld <= 1'b1;
      // read data lags the address by one cycle, so each state captures the previous byte
      case (r_state)
        S_RD1: r_word[31:24] <= mem_rdata;
        S_RD2: r_word[23:16] <= mem_rdata;
        S_RD3: r_word[15:8]  <= mem_rdata;
        S_RDW: begin
          r_fetch_instr <= {r_word, mem_rdata};
          r_fetch_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a behavioural
// synchronous-read byte memory attached.
module tb_imem_fetch_ctrl;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_err;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0]    mem [0:2047];
  int            total = 0;
  int            bad = 0;
  int            ack_cnt = 0;
  int            men_cnt = 0;
  int            gcnt = 0;
  logic          log_en = 1'b0;
  logic [7:0]    glog [0:7];

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (ld_ack) ack_cnt <= ack_cnt + 1;
    if (mem_en) men_cnt <= men_cnt + 1;
    if (log_en && gcnt < 8) begin
      if (ld_ack) begin
        glog[gcnt] <= "L";
        gcnt <= gcnt + 1;
      end else if (fetch_req && fetch_ready) begin
        glog[gcnt] <= "F";
        gcnt <= gcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d);
    int n;
    n = 0;
    ld_addr = a;
    ld_data = d;
    ld_req  = 1'b1;
    while (!ld_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ld_ack_seen", 32'(ld_ack), 32'd1);
    ld_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] instr,
                          output logic err, output int lat);
    int n;
    n = 0;
    fetch_addr = a;
    fetch_req  = 1'b1;
    while (!fetch_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    fetch_req  = 1'b0;
    fetch_addr = $urandom;
    n = 1;
    while (!fetch_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    instr = fetch_instr;
    err   = fetch_err;
    lat   = fetch_valid ? n : -1;
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(fetch_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] instr;
    logic        err;
    int          lat;
    int          men0;
    int          va;
    int          aa;
    int          vs;
    logic [31:0] vi;

    #3;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_err",   32'(fetch_err),   32'd0);
    chk("rst_fetch_instr", fetch_instr,      32'd0);
    chk("rst_ld_ack",      32'(ld_ack),      32'd0);
    chk("rst_mem_en",      32'(mem_en),      32'd0);
    chk("rst_mem_we",      32'(mem_we),      32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",   32'(mem_wdata),   32'd0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    ld_write(11'h000, 8'h00);
    ld_write(11'h001, 8'h50);
    ld_write(11'h002, 8'h00);
    ld_write(11'h003, 8'h93);
    chk("ld_ack_count", 32'(ack_cnt), 32'd4);

    do_fetch(32'h0, instr, err, lat);
    chk("f0_instr", instr, 32'h0050_0093);
    chk("f0_err", 32'(err), 32'd0);
    chk("f0_latency", 32'(lat), 32'd6);

    men0 = men_cnt;
    do_fetch(32'h2, instr, err, lat);
    chk("mis_instr", instr, 32'h0000_0013);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_no_mem_en", 32'(men_cnt - men0), 32'd0);

    ld_write(11'h7FC, 8'hAA);
    ld_write(11'h7FD, 8'hBB);
    ld_write(11'h7FE, 8'hCC);
    ld_write(11'h7FF, 8'hDD);
    do_fetch(32'h7FC, instr, err, lat);
    chk("top_instr", instr, 32'hAABB_CCDD);
    chk("top_err", 32'(err), 32'd0);
    do_fetch(32'h800, instr, err, lat);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_instr", instr, 32'h0000_0013);
    do_fetch(32'hFFFF_FFFC, instr, err, lat);
    chk("wrap_err", 32'(err), 32'd1);

    ld_addr    = 11'h010;
    ld_data    = 8'h5A;
    fetch_addr = 32'h0;
    log_en     = 1'b1;
    ld_req     = 1'b1;
    fetch_req  = 1'b1;
    for (int n = 0; n < 60 && gcnt < 4; n++) begin
      @(posedge clk); #1;
    end
    ld_req    = 1'b0;
    fetch_req = 1'b0;
    log_en    = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("arb_grants", 32'(gcnt >= 4), 32'd1);
    chk("arb_g0", 32'(glog[0]), 32'("L"));
    chk("arb_g1", 32'(glog[1]), 32'("F"));
    chk("arb_g2", 32'(glog[2]), 32'("L"));
    chk("arb_g3", 32'(glog[3]), 32'("F"));

    fetch_addr = 32'h7FC;
    fetch_req  = 1'b1;
    for (int n = 0; n < 20 && !fetch_ready; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    ld_addr = 11'h7FD;
    ld_data = 8'h11;
    ld_req  = 1'b1;
    va = -1;
    aa = -1;
    vi = '0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (fetch_valid && va < 0) begin
        va = n;
        vi = fetch_instr;
      end
      if (ld_ack && aa < 0) begin
        aa = n;
        ld_req = 1'b0;
      end
    end
    ld_req = 1'b0;
    chk("defer_valid_at", 32'(va), 32'd3);
    chk("defer_wr_at", 32'(aa), 32'd5);
    chk("defer_instr", vi, 32'hAABB_CCDD);
    do_fetch(32'h7FC, instr, err, lat);
    chk("defer_written", instr, 32'hAA11_CCDD);

    fetch_addr = 32'h0;
    fetch_req  = 1'b1;
    for (int n = 0; n < 20 && !fetch_ready; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd2_mem_en", 32'(mem_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_en", 32'(mem_en), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_fetch_instr", fetch_instr, 32'd0);
    chk("arst_fetch_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    vs = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (fetch_valid) vs++;
    end
    chk("arst_no_response", 32'(vs), 32'd0);
    do_fetch(32'h0, instr, err, lat);
    chk("post_rst_instr", instr, 32'h0050_0093);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
